// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw switch levels in, debounced levels and update pulse out.
// The master side (board/bench) drives switch_in; the debouncer drives the rest.
interface switch_debouncer_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] switch_in;
    logic [WIDTH-1:0] switch_out;
    logic             changed;

    modport master (
        output switch_in,
        input  switch_out,
        input  changed
    );

    modport slave (
        input  switch_in,
        output switch_out,
        output changed
    );
endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit stability counter for the board slide switches.
// Outputs are registered; a bit is accepted only after STABLE_CYCLES consecutive differing samples.
module switch_debouncer #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_W         = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    switch_debouncer_if.slave sw
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] switch_out_r;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r     [WIDTH];

    logic [WIDTH-1:0] out_nxt_s;
    logic [WIDTH-1:0] accept_s;
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];

    // Per-bit stability decision: any return to the output level clears the count.
    always_comb begin
        out_nxt_s = switch_out_r;
        accept_s  = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (sync2_r[i] == switch_out_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                out_nxt_s[i] = sync2_r[i];
                accept_s[i]  = 1'b1;
                cnt_nxt_s[i] = CNT_ZERO;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Synchroniser, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r      <= {WIDTH{1'b0}};
            sync2_r      <= {WIDTH{1'b0}};
            switch_out_r <= {WIDTH{1'b0}};
            changed_r    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r      <= sw.switch_in;
            sync2_r      <= sync1_r;
            switch_out_r <= out_nxt_s;
            changed_r    <= |accept_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign sw.switch_out = switch_out_r;
    assign sw.changed    = changed_r;
endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer at WIDTH=10, STABLE_CYCLES=4: directed table, corner sequences,
// and random stimulus against a sliding-window reference model.
module tb_switch_debouncer;
    localparam int W = 10;
    localparam int S = 4;

    logic clk;
    logic rst_n;

    switch_debouncer_if #(.WIDTH(W)) sif ();

    switch_debouncer #(
        .WIDTH(W),
        .STABLE_CYCLES(S),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a bit flips when the last S synchronised samples since its last event all differ.
    int           edge_n = 0;
    logic [W-1:0] m_s1   = '0;
    logic [W-1:0] m_s2   = '0;
    logic [W-1:0] m_out  = '0;
    logic         m_chg  = 1'b0;
    logic [W-1:0] hist [64];
    int           last_evt [W];

    typedef struct {
        logic         rn;
        logic [W-1:0] sw;
        logic [W-1:0] exp_out;
        logic         exp_chg;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic [W-1:0] swv);
        logic [W-1:0] acc;
        logic ok;
        edge_n++;
        if (!rn) begin
            m_s1  = '0;
            m_s2  = '0;
            m_out = '0;
            m_chg = 1'b0;
            for (int i = 0; i < W; i++) last_evt[i] = edge_n;
        end else begin
            hist[edge_n % 64] = m_s2;
            acc = '0;
            for (int i = 0; i < W; i++) begin
                if (edge_n - S + 1 > last_evt[i]) begin
                    ok = 1'b1;
                    for (int j = 0; j < S; j++)
                        if (hist[(edge_n - j) % 64][i] == m_out[i]) ok = 1'b0;
                    acc[i] = ok;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (acc[i]) begin
                    m_out[i]    = ~m_out[i];
                    last_evt[i] = edge_n;
                end
            end
            m_chg = |acc;
            m_s2  = m_s1;
            m_s1  = swv;
        end
    endtask

    task automatic step(input logic rn, input logic [W-1:0] swv);
        rst_n         = rn;
        sif.switch_in = swv;
        @(posedge clk);
        model_edge(rn, swv);
        #1;
        check("model_out", 32'(sif.switch_out), 32'(m_out));
        check("model_chg", 32'(sif.changed), 32'(m_chg));
    endtask

    task automatic add_vec(input logic rn, input logic [W-1:0] swv,
                           input logic [W-1:0] eo, input logic ec);
        vec_t v;
        v.rn = rn; v.sw = swv; v.exp_out = eo; v.exp_chg = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int r_a, r_b, pulses;
        logic [W-1:0] cur;

        for (int i = 0; i < 64; i++) hist[i] = '0;
        for (int i = 0; i < W; i++) last_evt[i] = 0;
        rst_n         = 1'b0;
        sif.switch_in = '0;

        // Reset with switches high, re-qualification after release, then a clean step.
        for (int i = 0; i < 3; i++) add_vec(1'b0, 10'h3FF, 10'h000, 1'b0);
        for (int i = 0; i < 5; i++) add_vec(1'b1, 10'h3FF, 10'h000, 1'b0);
        add_vec(1'b1, 10'h3FF, 10'h3FF, 1'b1);
        add_vec(1'b1, 10'h3FF, 10'h3FF, 1'b0);
        add_vec(1'b0, 10'h000, 10'h000, 1'b0);
        for (int i = 0; i < 5; i++) add_vec(1'b1, 10'b1_0_0001_0001, 10'h000, 1'b0);
        add_vec(1'b1, 10'b1_0_0001_0001, 10'b1_0_0001_0001, 1'b1);
        add_vec(1'b1, 10'b1_0_0001_0001, 10'b1_0_0001_0001, 1'b0);
        foreach (vecs[k]) begin
            step(vecs[k].rn, vecs[k].sw);
            check("tbl_out", 32'(sif.switch_out), 32'(vecs[k].exp_out));
            check("tbl_chg", 32'(sif.changed), 32'(vecs[k].exp_chg));
        end
        check("field_enable", 32'(sif.switch_out[9]), 32'd1);
        check("field_select", 32'(sif.switch_out[8]), 32'd0);
        check("field_a", 32'(sif.switch_out[7:4]), 32'd1);
        check("field_b", 32'(sif.switch_out[3:0]), 32'd1);

        // Bounce on bit 9 must be rejected, then a steady high is accepted.
        step(1'b0, 10'h000);
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 2; c++) begin
                step(1'b1, (p % 2 == 0) ? 10'h200 : 10'h000);
                check("bounce_quiet", 32'(sif.switch_out), 32'h0);
            end
        end
        r_a = -1; pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 10'h200);
            if (sif.changed) pulses++;
            if (r_a < 0 && sif.switch_out[9]) r_a = k;
        end
        check("bounce_rise_edge", 32'(r_a), 32'd5);
        check("bounce_pulses", 32'(pulses), 32'd1);

        // Independent bits: bit 8 at cycle 0, bit 0 at cycle 2.
        step(1'b0, 10'h000);
        r_a = -1; r_b = -1; pulses = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, (k >= 2) ? 10'h101 : 10'h100);
            if (sif.changed) pulses++;
            if (r_a < 0 && sif.switch_out[8]) r_a = k;
            if (r_b < 0 && sif.switch_out[0]) r_b = k;
        end
        check("indep_bit8_edge", 32'(r_a), 32'd5);
        check("indep_bit0_edge", 32'(r_b), 32'd7);
        check("indep_pulses", 32'(pulses), 32'd2);

        // Two bits on the same cycle give a single pulse.
        step(1'b0, 10'h000);
        r_a = -1; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 10'h00C);
            if (sif.changed) pulses++;
            if (r_a < 0 && sif.switch_out == 10'h00C) r_a = k;
        end
        check("same_cycle_edge", 32'(r_a), 32'd5);
        check("same_cycle_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of a count discards it.
        step(1'b0, 10'h000);
        for (int k = 0; k < 3; k++) step(1'b1, 10'h010);
        step(1'b0, 10'h010);
        check("midreset_out", 32'(sif.switch_out), 32'h0);
        r_a = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 10'h010);
            if (r_a < 0 && sif.switch_out[4]) r_a = k;
        end
        check("midreset_rise_edge", 32'(r_a), 32'd5);

        // Falling transition on bit 9 only.
        step(1'b0, 10'h000);
        for (int k = 0; k < 8; k++) step(1'b1, 10'h3FF);
        check("fall_start", 32'(sif.switch_out), 32'h3FF);
        r_a = -1; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 10'h1FF);
            if (sif.changed) pulses++;
            if (r_a < 0 && !sif.switch_out[9]) r_a = k;
        end
        check("fall_edge", 32'(r_a), 32'd5);
        check("fall_pulses", 32'(pulses), 32'd1);
        check("fall_final", 32'(sif.switch_out), 32'h1FF);

        // Random flips and occasional resets against the reference model.
        cur = sif.switch_in;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, W - 1)] ^= 1'b1;
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
